// File: rtl/spi_sipo_rx_if.sv
// Serial link and parallel-consumer signal bundle for the SPI SIPO receive stage.
// master = link/consumer side, slave = receiver side.
interface spi_sipo_rx_if #(
  parameter int unsigned D_PACK = 8
);
  logic              SCLK;
  logic              SER_IN;
  logic              SS_N;
  logic              C_PH;
  logic              DATA_ACK;
  logic [D_PACK-1:0] DATA_OUT;
  logic              DATA_VALID;
  logic              OVERRUN;
  logic              FRAME_ERR;
  logic              BUSY;

  modport master (
    output SCLK, SER_IN, SS_N, C_PH, DATA_ACK,
    input  DATA_OUT, DATA_VALID, OVERRUN, FRAME_ERR, BUSY
  );

  modport slave (
    input  SCLK, SER_IN, SS_N, C_PH, DATA_ACK,
    output DATA_OUT, DATA_VALID, OVERRUN, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/spi_sipo_rx.sv
// SPI serial-in/parallel-out receiver: oversampled SCLK/SER_IN/SS_N, word handshake.
// Define SPI_SIPO_MSB_FIRST_EN for MSB-first links (default LSB first).
module spi_sipo_rx #(
  parameter int unsigned D_PACK      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  spi_sipo_rx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(D_PACK);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(D_PACK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_LOAD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ser_sync;
  logic [SYNC_STAGES-1:0] sel_sync;
  logic                   sclk_d;
  logic [CNT_W-1:0]       cnt;
  logic [D_PACK-1:0]      shreg;
  logic [D_PACK-1:0]      data_out;
  logic                   data_valid;
  logic                   overrun;
  logic                   frame_err;

  logic                   sclk_s;
  logic                   ser_s;
  logic                   sel_s;
  logic                   sample_c;
  logic [D_PACK-1:0]      shift_c;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ser_s  = ser_sync[SYNC_STAGES-1];
  assign sel_s  = sel_sync[SYNC_STAGES-1];

  // Select is carried active-high so the reset value 0 means "idle link".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync <= '0;
      ser_sync  <= '0;
      sel_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      ser_sync  <= {ser_sync[SYNC_STAGES-2:0], bus.SER_IN};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], ~bus.SS_N};
      sclk_d    <= sclk_s;
    end
  end

  always_comb begin
    sample_c = bus.C_PH ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
`ifdef SPI_SIPO_MSB_FIRST_EN
    shift_c  = {shreg[D_PACK-2:0], ser_s};
`else
    shift_c  = {ser_s, shreg[D_PACK-1:1]};
`endif
  end

  // Receive FSM and output handshake; in RECV a final sample edge wins over SS_N rising.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (bus.DATA_ACK) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (sel_s) begin
            state <= S_RECV;
            if (sample_c) begin
              shreg <= shift_c;
              cnt   <= CNT_W'(1);
            end
          end
        end
        S_RECV: begin
          if (sample_c) begin
            shreg <= shift_c;
            if (cnt == LAST_BIT) begin
              cnt   <= '0;
              state <= S_LOAD;
            end else if (!sel_s) begin
              frame_err <= 1'b1;
              cnt       <= '0;
              shreg     <= '0;
              state     <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (!sel_s) begin
            frame_err <= (cnt != '0);
            cnt       <= '0;
            shreg     <= '0;
            state     <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (!data_valid || bus.DATA_ACK) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= sel_s ? S_RECV : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.DATA_OUT   = data_out;
  assign bus.DATA_VALID = data_valid;
  assign bus.OVERRUN    = overrun;
  assign bus.FRAME_ERR  = frame_err;
  assign bus.BUSY       = sel_s;

endmodule

// File: tb/tb_spi_sipo_rx.sv
// Bench for spi_sipo_rx: vector table, hand-written corner sequences, random frames vs word-level model.
module tb_spi_sipo_rx;

  localparam int unsigned D_PACK = 8;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_bad;
  int   fe_cnt;
  int   fe_run;
  int   fe_max;
  int   exp_fe;

  spi_sipo_rx_if #(.D_PACK(D_PACK)) bus ();

  spi_sipo_rx #(.D_PACK(D_PACK), .SYNC_STAGES(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] word;
    logic       cph;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_ovr;
    logic       do_ack;
  } vec_t;

  vec_t tbl [6];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count FRAME_ERR pulses and their longest run in CLK cycles.
  initial begin
    fe_cnt = 0;
    fe_run = 0;
    fe_max = 0;
  end
  always @(negedge CLK) begin
    if (bus.FRAME_ERR === 1'b1) begin
      fe_cnt = fe_cnt + 1;
      fe_run = fe_run + 1;
      if (fe_run > fe_max) fe_max = fe_run;
    end else begin
      fe_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] w, input int i);
`ifdef SPI_SIPO_MSB_FIRST_EN
    return w[3'(7 - i)];
`else
    return w[3'(i)];
`endif
  endfunction

  task automatic frame_begin(input logic cph);
    bus.C_PH = cph;
    bus.SS_N = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    bus.SS_N = 1'b1;
    tick(8);
  endtask

  // SCLK = CLK/8; C_PH=0 data changes on falling, C_PH=1 on rising edge.
  task automatic send_bits(input logic [7:0] w, input int nbits, input logic cph);
    for (int i = 0; i < nbits; i++) begin
      if (!cph) begin
        bus.SER_IN = bit_of(w, i);
        tick(4);
        bus.SCLK = 1'b1;
        tick(4);
        bus.SCLK = 1'b0;
      end else begin
        bus.SCLK   = 1'b1;
        bus.SER_IN = bit_of(w, i);
        tick(4);
        bus.SCLK = 1'b0;
        tick(4);
      end
    end
  endtask

  task automatic ack_pulse();
    bus.DATA_ACK = 1'b1;
    tick(1);
    bus.DATA_ACK = 1'b0;
    tick(1);
  endtask

  logic [7:0] rm_out;
  logic       rm_valid;
  logic       rm_ovr;

  task automatic model_deliver(input logic [7:0] w);
    if (!rm_valid) begin
      rm_out   = w;
      rm_valid = 1'b1;
    end else begin
      rm_ovr = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] w;
    logic       cph;
    int         nw;
    int         part;

    n_vec = 0;
    n_bad = 0;
    exp_fe = 0;

    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h12, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h34, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{8'h0F, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

    RST          = 1'b1;
    bus.SCLK     = 1'b0;
    bus.SER_IN   = 1'b0;
    bus.SS_N     = 1'b1;
    bus.C_PH     = 1'b0;
    bus.DATA_ACK = 1'b0;
    tick(3);
    RST = 1'b0;
    tick(2);
    chk("reset data_out", 32'(bus.DATA_OUT), 32'h0);
    chk("reset valid", 32'(bus.DATA_VALID), 32'h0);
    chk("reset overrun", 32'(bus.OVERRUN), 32'h0);
    chk("reset frame_err", 32'(bus.FRAME_ERR), 32'h0);
    chk("reset busy", 32'(bus.BUSY), 32'h0);

    for (int v = 0; v < 6; v++) begin
      frame_begin(tbl[v].cph);
      chk("tbl busy", 32'(bus.BUSY), 32'h1);
      send_bits(tbl[v].word, 8, tbl[v].cph);
      frame_end();
      chk("tbl data_out", 32'(bus.DATA_OUT), 32'(tbl[v].exp_out));
      chk("tbl valid", 32'(bus.DATA_VALID), 32'(tbl[v].exp_valid));
      chk("tbl overrun", 32'(bus.OVERRUN), 32'(tbl[v].exp_ovr));
      chk("tbl busy idle", 32'(bus.BUSY), 32'h0);
      if (tbl[v].do_ack) begin
        ack_pulse();
        chk("tbl ack valid", 32'(bus.DATA_VALID), 32'h0);
        chk("tbl ack overrun", 32'(bus.OVERRUN), 32'h0);
      end
    end
    ack_pulse();
    chk("pre-latency valid", 32'(bus.DATA_VALID), 32'h0);

    // DATA_VALID must rise exactly 4 CLK edges after the 8th rising SCLK.
    frame_begin(1'b0);
    send_bits(8'hA5, 7, 1'b0);
    bus.SER_IN = bit_of(8'hA5, 7);
    tick(4);
    bus.SCLK = 1'b1;
    tick(3);
    chk("latency valid early", 32'(bus.DATA_VALID), 32'h0);
    tick(1);
    chk("latency valid", 32'(bus.DATA_VALID), 32'h1);
    chk("latency data", 32'(bus.DATA_OUT), 32'hA5);
    chk("latency busy", 32'(bus.BUSY), 32'h1);
    bus.SCLK = 1'b0;
    frame_end();
    ack_pulse();
    chk("ack clears valid", 32'(bus.DATA_VALID), 32'h0);

    // Back-to-back words with ACK landing in the LOAD cycle of the second.
    frame_begin(1'b0);
    send_bits(8'h55, 8, 1'b0);
    send_bits(8'hAA, 7, 1'b0);
    bus.SER_IN = bit_of(8'hAA, 7);
    tick(4);
    bus.SCLK = 1'b1;
    tick(3);
    chk("b2b first data", 32'(bus.DATA_OUT), 32'h55);
    chk("b2b first valid", 32'(bus.DATA_VALID), 32'h1);
    bus.DATA_ACK = 1'b1;
    tick(1);
    bus.DATA_ACK = 1'b0;
    chk("ack+load data", 32'(bus.DATA_OUT), 32'hAA);
    chk("ack+load valid", 32'(bus.DATA_VALID), 32'h1);
    chk("ack+load overrun", 32'(bus.OVERRUN), 32'h0);
    bus.SCLK = 1'b0;
    frame_end();
    chk("ack+load valid held", 32'(bus.DATA_VALID), 32'h1);
    ack_pulse();

    // Back-to-back words with no ACK: second dropped.
    frame_begin(1'b0);
    send_bits(8'h12, 8, 1'b0);
    send_bits(8'h34, 8, 1'b0);
    frame_end();
    chk("drop data", 32'(bus.DATA_OUT), 32'h12);
    chk("drop overrun", 32'(bus.OVERRUN), 32'h1);
    chk("drop valid", 32'(bus.DATA_VALID), 32'h1);

    // SS_N raised after 5 bits.
    frame_begin(1'b0);
    send_bits(8'hFF, 5, 1'b0);
    frame_end();
    exp_fe = exp_fe + 1;
    chk("frame_err count", 32'(fe_cnt), 32'(exp_fe));
    chk("frame_err width", 32'(fe_max), 32'h1);
    chk("frame_err valid kept", 32'(bus.DATA_VALID), 32'h1);
    chk("frame_err data kept", 32'(bus.DATA_OUT), 32'h12);
    ack_pulse();
    chk("ack clears overrun", 32'(bus.OVERRUN), 32'h0);
    chk("ack clears valid 2", 32'(bus.DATA_VALID), 32'h0);
    frame_begin(1'b0);
    send_bits(8'h0F, 8, 1'b0);
    frame_end();
    chk("after frame_err data", 32'(bus.DATA_OUT), 32'h0F);
    chk("after frame_err valid", 32'(bus.DATA_VALID), 32'h1);

    // Reset mid-frame clears outputs immediately.
    frame_begin(1'b1);
    send_bits(8'hFF, 3, 1'b1);
    RST = 1'b1;
    #1;
    chk("midreset data", 32'(bus.DATA_OUT), 32'h0);
    chk("midreset valid", 32'(bus.DATA_VALID), 32'h0);
    chk("midreset overrun", 32'(bus.OVERRUN), 32'h0);
    chk("midreset busy", 32'(bus.BUSY), 32'h0);
    bus.SS_N = 1'b1;
    bus.SCLK = 1'b0;
    tick(3);
    RST = 1'b0;
    tick(4);
    frame_begin(1'b1);
    send_bits(8'hC3, 8, 1'b1);
    frame_end();
    chk("post-reset data", 32'(bus.DATA_OUT), 32'hC3);
    chk("post-reset valid", 32'(bus.DATA_VALID), 32'h1);
    ack_pulse();

    // Random frames: 1-2 words per frame, optional trailing partial word, random ACK.
    rm_out   = 8'hC3;
    rm_valid = 1'b0;
    rm_ovr   = 1'b0;
    for (int it = 0; it < 30; it++) begin
      cph  = 1'($urandom_range(0, 1));
      nw   = int'($urandom_range(1, 2));
      part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      frame_begin(cph);
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        send_bits(w, 8, cph);
        model_deliver(w);
      end
      if (part != 0) begin
        send_bits(8'($urandom), part, cph);
        exp_fe = exp_fe + 1;
      end
      frame_end();
      chk("rand data_out", 32'(bus.DATA_OUT), 32'(rm_out));
      chk("rand valid", 32'(bus.DATA_VALID), 32'(rm_valid));
      chk("rand overrun", 32'(bus.OVERRUN), 32'(rm_ovr));
      chk("rand frame_err count", 32'(fe_cnt), 32'(exp_fe));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        rm_valid = 1'b0;
        rm_ovr   = 1'b0;
        chk("rand ack valid", 32'(bus.DATA_VALID), 32'h0);
      end
    end
    chk("frame_err max width", 32'(fe_max), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_sipo_rx.md
Name: spi_sipo_rx

Overview:
Serial-in/parallel-out receive stage of the SPI module. It is the downstream partner of the PISO transmit serializer: it recovers D_PACK-bit words from SER_IN/SCLK framed by SS_N. The serial signals are oversampled in the system CLK domain. Each completed word is presented on DATA_OUT with a valid/ack handshake to the parallel consumer. Bit order and clock-phase convention match the transmitter: LSB first; with C_PH=0 data changes on falling SCLK, with C_PH=1 on rising SCLK.

Parameters:
D_PACK, 8, word width in bits (≥2).
SYNC_STAGES, 2, synchronizer depth on SCLK, SER_IN and SS_N (≥2).

Ports:
CLK  input  1  system clock; must be ≥4× SCLK frequency.
RST  input  1  asynchronous, active-high reset.
SCLK  input  1  serial clock from the link, asynchronous to CLK.
SER_IN  input  1  serial data from the link.
SS_N  input  1  slave select, active low; frames a word.
C_PH  input  1  phase select: 0 samples on rising SCLK, 1 samples on falling SCLK. Must be static while SS_N=0.
DATA_ACK  input  1  consumer accepts DATA_OUT.
DATA_OUT  output  D_PACK  last received word.
DATA_VALID  output  1  DATA_OUT holds an unconsumed word.
OVERRUN  output  1  sticky: a word was dropped because DATA_VALID was still high.
FRAME_ERR  output  1  one-cycle pulse: SS_N deasserted mid-word.
BUSY  output  1  high while SS_N is synchronized low.

Behaviour:
- Reset (async, RST=1): DATA_OUT=0, DATA_VALID=0, OVERRUN=0, FRAME_ERR=0, BUSY=0. Bit counter=0, shift register=0, synchronizers and edge history loaded to idle (SCLK=0, SS_N=1). Reset mid-word discards the partial word.
- Synchronization: SCLK, SER_IN and SS_N each pass through SYNC_STAGES flops. One extra history flop on synced SCLK provides edge detect.
- Sample edge: synced rising edge when C_PH=0, synced falling edge when C_PH=1. Edges are ignored while synced SS_N=1.
- FSM states:
  - IDLE: synced SS_N=1, counter=0. Synced SS_N falling → RECV.
  - RECV: on each sample edge, shift in synced SER_IN. LSB first, so the first bit lands in bit 0 of the final word. Counter increments.
    - When the D_PACK-th bit is shifted: go to LOAD, counter wraps to 0.
    - Synced SS_N rising with counter≠0: FRAME_ERR=1 for one cycle, partial word discarded, go to IDLE.
    - Synced SS_N rising with counter=0: go to IDLE silently.
  - LOAD (one cycle):
    - If DATA_VALID=0, or DATA_ACK=1 in this cycle: DATA_OUT←word, DATA_VALID=1.
    - Otherwise: word dropped, DATA_OUT unchanged, OVERRUN←1.
    - Next state is RECV if SS_N is still low (back-to-back words), else IDLE.
- Latency: DATA_VALID rises SYNC_STAGES+2 CLK edges after the final sample SCLK edge at the pin.
- Handshake:
  - DATA_VALID stays high until sampled with DATA_ACK=1; it clears on the next CLK edge. DATA_ACK with DATA_VALID=0 has no effect.
  - DATA_ACK clears OVERRUN on the same edge.
  - ACK and LOAD in the same cycle: new word loaded, DATA_VALID stays 1, OVERRUN cleared, no drop.
- BUSY = synced SS_N inverted.
- Simultaneous SS_N rise and final sample edge in the same CLK cycle: the bit is shifted, the word completes and loads normally, no FRAME_ERR.

Optional Feature:
SPI_SIPO_MSB_FIRST_EN
- Defined: the shift direction is reversed; the first received bit lands in DATA_OUT[D_PACK-1] (MSB-first links).
- Undefined: LSB first as above. All other timing is identical.

Test Plan:
- C_PH=0, SCLK=CLK/8, send 0xA5 LSB-first under SS_N low → DATA_OUT=0xA5, DATA_VALID=1 4 CLK after the 8th rising SCLK; DATA_ACK pulse → DATA_VALID=0 next cycle.
- C_PH=1, send 0x3C, sampling on falling SCLK → DATA_OUT=0x3C; the same stream with C_PH=0 is not required to match.
- Back-to-back 0x12, 0x34 with no ACK → DATA_OUT=0x12, OVERRUN=1, 0x34 dropped; ACK → OVERRUN=0, DATA_VALID=0.
- Back-to-back 0x55, 0xAA with ACK issued in the LOAD cycle of word 2 → DATA_OUT=0xAA, DATA_VALID stays 1, OVERRUN=0.
- Raise SS_N after 5 bits → FRAME_ERR single pulse, DATA_VALID unchanged; next full frame 0x0F received correctly.
- Assert RST after 3 bits of a frame → all outputs 0 immediately; after release, frame 0xC3 → DATA_OUT=0xC3.
